// File: rtl/div_pkg.sv
// Shared encodings for the multi-cycle HI/LO divider.
// Optional build macro: DIV_ZERO_DETECT_EN (short-circuits a zero divisor
// through the BYZERO state instead of running the full iteration sequence).
package div_pkg;

  // FSM state encodings, kept as plain 2-bit constants for legacy users.
  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  // Result-valid and request levels.
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Operand width; the result bus is twice this ({HI, LO}).
  localparam int DIV_DATA_W = 32;

  // Zero-divisor short-circuit, selected at build time.
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DIV_ZERO_DETECT = 1'b1;
`else
  localparam bit DIV_ZERO_DETECT = 1'b0;
`endif

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, one quotient bit per clock.
// result_o = {remainder, quotient}: [63:32] feeds HI, [31:0] feeds LO.
// Handshake: EX raises start_i and holds it until it observes ready_o; the
// result is held with ready_o high for as long as start_i stays high, and
// both clear on the edge after start_i drops (or annul_i rises). A request
// is only sampled in FREE; operands are captured on that single edge.
// annul_i aborts an in-flight division without ever exposing a result.
// Optional build macro: DIV_ZERO_DETECT_EN (see div_pkg).
import div_pkg::*;

module div #(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic [1:0]            dbg_state_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   work_q, work_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                signed_q, signed_d;
  logic                neg1_q, neg1_d;
  logic                neg2_q, neg2_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   abs1, abs2;
  logic [DATA_W:0]     temp;
  logic [DATA_W-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

  // Operand magnitudes, iteration subtractor and final sign correction.
  always_comb begin
    abs1    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    abs2    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    temp    = work_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};
    quo_raw = work_q[DATA_W-1:0];
    rem_raw = work_q[2*DATA_W:DATA_W+1];
    quo_fix = (signed_q && (neg1_q ^ neg2_q)) ? -quo_raw : quo_raw;
    rem_fix = (signed_q && neg1_q) ? -rem_raw : rem_raw;
  end

  // Next-state and datapath update for the FREE/BYZERO/ON/END sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DIV_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (start_i == DIV_START && !annul_i) begin
          if (DIV_ZERO_DETECT && opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            work_d    = {{DATA_W{1'b0}}, abs1, 1'b0};
            divisor_d = abs2;
            signed_d  = signed_div_i;
            neg1_d    = opdata1_i[DATA_W-1];
            neg2_d    = opdata2_i[DATA_W-1];
            cnt_d     = '0;
            state_d   = DIV_ON;
          end
        end
      end

      DIV_BY_ZERO: begin
        result_d = '0;
        ready_d  = DIV_RESULT_READY;
        state_d  = DIV_END;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          // A negative trial difference means the divisor does not fit:
          // shift in a 0, otherwise keep the difference and shift in a 1.
          if (temp[DATA_W]) begin
            work_d = {work_q[2*DATA_W-1:0], 1'b0};
          end else begin
            work_d = {temp[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP || annul_i) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end

      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  // State registers; reset returns everything to idle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the HI/LO divider.
// Optional build macro: DIV_ZERO_DETECT_EN (changes zero-divisor expectations).
module tb_div;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic [1:0]  dbg_state_o;

  always #5 clk = ~clk;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .dbg_state_o  (dbg_state_o)
  );

`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Arithmetic result of one division, straight from the operand rules.
  function automatic logic [63:0] mdl(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, lq, lr;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      if (ZD) return 64'd0;
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
      return {r, q};
    end
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Timeline: idle -> busy for a fixed number of edges -> holding result.
  int          m_phase;
  int          m_left;
  logic [63:0] m_res;
  logic        exp_ready;
  logic [63:0] exp_result;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase    <= 0;
      m_left     <= 0;
      m_res      <= 64'd0;
      exp_ready  <= 1'b0;
      exp_result <= 64'd0;
    end else begin
      case (m_phase)
        0: if (start_i && !annul_i) begin
          m_res   <= mdl(opdata1_i, opdata2_i, signed_div_i);
          m_left  <= (ZD && opdata2_i == 32'd0) ? 1 : 33;
          m_phase <= 1;
        end
        1: if (annul_i) begin
          m_phase <= 0;
        end else if (m_left == 1) begin
          m_phase    <= 2;
          exp_ready  <= 1'b1;
          exp_result <= m_res;
        end else begin
          m_left <= m_left - 1;
        end
        default: if (!start_i || annul_i) begin
          m_phase    <= 0;
          exp_ready  <= 1'b0;
          exp_result <= 64'd0;
        end
      endcase
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (cmp_en) check("cycle", {ready_o, result_o}, {exp_ready, exp_result});
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    annul_i      = 1'b0;
  endtask

  // Wait for ready_o (bounded), check latency and value, then release start.
  task automatic wait_ready(input string name, input int exp_lat, input logic [63:0] lit);
    int lat = 0;
    bit got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      got = ready_o;
    end
    check({name, " ready"}, 65'(got), 65'(1));
    check({name, " latency"}, 65'(lat), 65'(exp_lat));
    check({name, " result"}, {1'b0, result_o}, {1'b0, lit});
    // Later operand changes while holding start must not disturb the result.
    repeat (2) begin
      @(negedge clk);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    check({name, " held"}, {ready_o, result_o}, {1'b1, lit});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " clear"}, {ready_o, result_o}, 65'd0);
  endtask

  task automatic run_case(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] lit, input int lat);
    check({name, " model"}, {1'b0, mdl(a, b, s)}, {1'b0, lit});
    launch(a, b, s);
    wait_ready(name, lat, lit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    repeat (3) @(negedge clk);
    check("reset", {ready_o, result_o}, 65'd0);
    check("reset state", 65'(dbg_state_o), 65'(2'b00));
    cmp_en = 1'b1;
    rst    = 1'b1;

    run_case("u100/7",   32'd100,        32'd7,          1'b0, {32'd2, 32'd14}, 34);
    run_case("s-100/7",  32'hFFFF_FF9C,  32'd7,          1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 34);
    run_case("s100/-7",  32'd100,        32'hFFFF_FFF9,  1'b1, {32'h0000_0002, 32'hFFFF_FFF2}, 34);
    run_case("s-7/-2",   32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, {32'hFFFF_FFFF, 32'h0000_0003}, 34);
    run_case("s ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0000_0000, 32'h8000_0000}, 34);
    run_case("uFFFF/1",  32'hFFFF_FFFF,  32'd1,          1'b0, {32'd0, 32'hFFFF_FFFF}, 34);
    run_case("uFFFF/16", 32'hFFFF_FFFF,  32'd16,         1'b0, {32'h0000_000F, 32'h0FFF_FFFF}, 34);
    run_case("u7/100",   32'd7,          32'd100,        1'b0, {32'd7, 32'd0}, 34);
    run_case("u5/0",     32'd5,          32'd0,          1'b0,
             ZD ? 64'd0 : {32'd5, 32'hFFFF_FFFF}, ZD ? 2 : 34);
    run_case("s-5/0",    32'hFFFF_FFFB,  32'd0,          1'b1,
             ZD ? 64'd0 : {32'hFFFF_FFFB, 32'h0000_0001}, ZD ? 2 : 34);

    // Annul at cnt=10, then an immediate fresh request with start still high.
    launch(32'd20, 32'd3, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul state", 65'(dbg_state_o), 65'(2'b00));
    check("annul out", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    annul_i   = 1'b0;
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    wait_ready("u9/3", 34, {32'd0, 32'd3});

    // Asynchronous reset between edges in the middle of an iteration.
    launch(32'd1000, 32'd9, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async rst", {ready_o, result_o}, 65'd0);
    check("async rst state", 65'(dbg_state_o), 65'(2'b00));
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_case("u50/5", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 34);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
